// File: rtl/qspi_mon_pkg.sv
// Shared types and helpers for the (Q)SPI capture datapath.
`timescale 1ns/1ps
package qspi_mon_pkg;

    typedef enum logic [1:0] {
        LM_X1 = 2'd0,
        LM_X2 = 2'd1,
        LM_X4 = 2'd2
    } lane_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

    // FIFO entry: {sof, data[7:0]}
    localparam int unsigned ENTRY_W = 9;

    // Narrow the requested mode to what the instantiated lane count supports.
    function automatic lane_mode_e clamp_mode(input logic [1:0] req, input int unsigned lanes);
        if (req >= 2'd2 && lanes >= 4) return LM_X4;
        if (req >= 2'd1 && lanes >= 2) return LM_X2;
        return LM_X1;
    endfunction

    function automatic logic [2:0] bits_per_edge(input lane_mode_e m);
        case (m)
            LM_X1:   return 3'd1;
            LM_X2:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Index of the sample edge that completes a byte (8/4/2 edges per byte).
    function automatic logic [2:0] last_edge(input lane_mode_e m);
        case (bits_per_edge(m))
            3'd1:    return 3'd7;
            3'd2:    return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/qspi_mon_fifo.sv
// First-word-fall-through synchronous FIFO with simultaneous push/pop.
`timescale 1ns/1ps
module qspi_mon_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full,
    output logic             accepted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;

    // Push into a full FIFO is allowed when a pop frees the slot this cycle.
    always_comb begin
        valid    = (count != '0);
        full     = (count == FULL_CNT);
        do_pop   = pop && valid;
        accepted = push && (!full || do_pop);
        rdata    = valid ? mem[rd_ptr] : '0;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accepted) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            if (accepted && !do_pop)      count <= count + 1'b1;
            else if (!accepted && do_pop) count <= count - 1'b1;
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (accepted) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/qspi_capture_core.sv
// Passive x1/x2/x4 (Q)SPI sniffer: synchronise, assemble bytes, buffer, stream out.
`timescale 1ns/1ps
module qspi_capture_core
    import qspi_mon_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned BCNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [1:0]        lane_mode,
    input  logic              clr_status,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic [LANES-1:0]  spi_dq,
    output logic [7:0]        out_data,
    output logic              out_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BCNT_W-1:0] byte_cnt,
    output logic [15:0]       drop_cnt,
    output logic              partial_err
);

    localparam int unsigned SW = LANES + 2;

    logic [SW-1:0]    sync_r [SYNC_STAGES];
    logic             s_clk, s_cs, prev_clk, prev_cs;
    logic [LANES-1:0] s_dq;
    logic [3:0]       s_dq4, dq_q;
    logic             clk_rise_q, clk_fall_q, cs_rise_q, cs_fall_q;

    frame_state_e state, state_n;
    lane_mode_e   cfg_mode, cfg_mode_n;
    logic         cfg_rise, cfg_rise_n, samp;
    logic [7:0]   sr, sr_n, push_byte, push_byte_n;
    logic [2:0]   ecnt, ecnt_n;
    logic         sof_pend, sof_pend_n, push_q, push_n, push_sof, push_sof_n, perr_set;

    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full, push_ok, pop;

    always_comb begin
        {s_clk, s_cs, s_dq} = sync_r[SYNC_STAGES-1];
        s_dq4 = '0;
        s_dq4[LANES-1:0] = s_dq;
    end

    // Synchroniser chain for the raw bus signals.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
        end else begin
            sync_r[0] <= {spi_clk, spi_cs, spi_dq};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    // Registered edge events, with data delayed to stay aligned to them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_clk   <= 1'b0;
            prev_cs    <= 1'b0;
            clk_rise_q <= 1'b0;
            clk_fall_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            dq_q       <= '0;
        end else begin
            prev_clk   <= s_clk;
            prev_cs    <= s_cs;
            clk_rise_q <= s_clk & ~prev_clk;
            clk_fall_q <= ~s_clk & prev_clk;
            cs_rise_q  <= s_cs & ~prev_cs;
            cs_fall_q  <= ~s_cs & prev_cs;
            dq_q       <= s_dq4;
        end
    end

    // Frame FSM state and shift/bit counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cfg_mode  <= LM_X1;
            cfg_rise  <= 1'b0;
            sr        <= '0;
            ecnt      <= '0;
            sof_pend  <= 1'b0;
            push_q    <= 1'b0;
            push_byte <= '0;
            push_sof  <= 1'b0;
        end else begin
            state     <= state_n;
            cfg_mode  <= cfg_mode_n;
            cfg_rise  <= cfg_rise_n;
            sr        <= sr_n;
            ecnt      <= ecnt_n;
            sof_pend  <= sof_pend_n;
            push_q    <= push_n;
            push_byte <= push_byte_n;
            push_sof  <= push_sof_n;
        end
    end

    // Next-state: frame start/stop, bit shifting, byte completion.
    // A sample edge landing with cs rising is shifted first, so a completing
    // edge pushes its byte and leaves the counter at zero (no partial error).
    always_comb begin
        state_n     = state;
        cfg_mode_n  = cfg_mode;
        cfg_rise_n  = cfg_rise;
        sr_n        = sr;
        ecnt_n      = ecnt;
        sof_pend_n  = sof_pend;
        push_n      = 1'b0;
        push_byte_n = push_byte;
        push_sof_n  = push_sof;
        perr_set    = 1'b0;
        samp        = cfg_rise ? clk_rise_q : clk_fall_q;
        case (state)
            ST_IDLE: begin
                if (cs_fall_q && enable) begin
                    state_n    = ST_ACTIVE;
                    ecnt_n     = '0;
                    sof_pend_n = 1'b1;
                    cfg_mode_n = clamp_mode(lane_mode, LANES);
                    cfg_rise_n = (cpol == cpha);
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                    ecnt_n  = '0;
                end else begin
                    if (samp) begin
                        case (cfg_mode)
                            LM_X1:   sr_n = {sr[6:0], dq_q[0]};
                            LM_X2:   sr_n = {sr[5:0], dq_q[1:0]};
                            default: sr_n = {sr[3:0], dq_q};
                        endcase
                        if (ecnt == last_edge(cfg_mode)) begin
                            ecnt_n      = '0;
                            push_n      = 1'b1;
                            push_byte_n = sr_n;
                            push_sof_n  = sof_pend;
                            sof_pend_n  = 1'b0;
                        end else begin
                            ecnt_n = ecnt + 3'd1;
                        end
                    end
                    if (cs_rise_q) begin
                        state_n  = ST_IDLE;
                        perr_set = (ecnt_n != '0);
                        ecnt_n   = '0;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign pop = out_valid && out_ready;

    qspi_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .wdata    ({push_sof, push_byte}),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .valid    (out_valid),
        .full     (fifo_full),
        .accepted (push_ok)
    );

    assign {out_sof, out_data} = fifo_rdata;

    // Status counters and sticky partial-byte flag; clr_status has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt    <= '0;
            drop_cnt    <= '0;
            partial_err <= 1'b0;
        end else begin
            if (push_ok) byte_cnt <= byte_cnt + BCNT_W'(1);
            if (clr_status) begin
                drop_cnt    <= '0;
                partial_err <= 1'b0;
            end else begin
                if (push_q && fifo_full && !pop && drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
                if (perr_set) partial_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qspi_capture_core.sv
// Scoreboard bench for qspi_capture_core: bus-level SPI driver, byte-level model.
`timescale 1ns/1ps
module tb_qspi_capture_core;

    localparam int unsigned LANES = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BW    = 8;
    localparam int          H     = 24;   // SPI half period, 4 system clocks

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable, cpol, cpha, clr_status, spi_clk, spi_cs, out_ready;
    logic [1:0]       lane_mode;
    logic [LANES-1:0] spi_dq;
    logic [7:0]       out_data;
    logic             out_sof, out_valid, partial_err;
    logic [BW-1:0]    byte_cnt;
    logic [15:0]      drop_cnt;

    qspi_capture_core #(
        .LANES       (LANES),
        .SYNC_STAGES (SYNC),
        .FIFO_DEPTH  (DEPTH),
        .BCNT_W      (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cpol        (cpol),
        .cpha        (cpha),
        .lane_mode   (lane_mode),
        .clr_status  (clr_status),
        .spi_clk     (spi_clk),
        .spi_cs      (spi_cs),
        .spi_dq      (spi_dq),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .byte_cnt    (byte_cnt),
        .drop_cnt    (drop_cnt),
        .partial_err (partial_err)
    );

    always #3 clk = ~clk;

    int         n_chk = 0, n_pass = 0;
    logic [8:0] sb_q[$];
    int         m_cnt = 0, m_drop = 0, accept_cap = 1000;
    bit         m_perr = 0, model_on = 1, rand_ready = 0;
    logic [7:0] fbytes [8];
    event       byte_edge;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pop expected entries on every handshake; check hold stability.
    logic [8:0] prev_out;
    bit         hold = 0;
    always @(negedge clk) begin
        if (!rst) begin
            hold = 0;
        end else begin
            if (hold && out_valid) chk("hold_stable", {out_sof, out_data}, prev_out);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_byte: got %0h expected none", {out_sof, out_data});
                end else begin
                    chk("byte", {out_sof, out_data}, sb_q.pop_front());
                end
            end
            hold     = out_valid && !out_ready;
            prev_out = {out_sof, out_data};
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
    end

    // Drive one CS frame: nb full bytes from fbytes, then 'extra' partial groups.
    task automatic spi_frame(input bit cp, input bit ch, input logic [1:0] lm,
                             input int nb, input int extra, input bit toggle);
        int         bpe, gpb, ng, sh;
        logic [3:0] v, mask;
        bit         sof;
        bpe  = (lm == 2'd0) ? 1 : (lm == 2'd1) ? 2 : 4;
        gpb  = 8 / bpe;
        ng   = nb * gpb + extra;
        mask = 4'((1 << bpe) - 1);
        sof  = 1;
        @(posedge clk); #1;
        cpol = cp; cpha = ch; lane_mode = lm; spi_clk = cp; spi_cs = 1'b1;
        #(2*H);
        spi_cs = 1'b0;
        #(H);
        for (int g = 0; g < ng; g++) begin
            if (toggle && g == 1) begin
                cpol      = ~cp;
                lane_mode = (lm == 2'd0) ? 2'd2 : 2'd0;
            end
            v = 4'($urandom);
            if (g < nb * gpb) begin
                sh = 8 - bpe * ((g % gpb) + 1);
                v  = (v & ~mask) | (4'(fbytes[g / gpb] >> sh) & mask);
            end
            if (!ch) begin
                spi_dq = v; #(H); spi_clk = ~cp;
            end else begin
                spi_clk = ~cp; spi_dq = v; #(H); spi_clk = cp;
            end
            if (g < nb * gpb && (g % gpb) == gpb - 1) begin
                -> byte_edge;
                if (model_on) begin
                    if (accept_cap > 0) begin
                        sb_q.push_back({sof, fbytes[g / gpb]});
                        m_cnt++;
                        accept_cap--;
                    end else begin
                        m_drop++;
                    end
                end
                sof = 0;
            end
            #(H);
            if (!ch) spi_clk = cp;
        end
        #(H);
        spi_cs = 1'b1;
        #(H);
        if (model_on && extra > 0) m_perr = 1;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb_q.size() != 0 || out_valid) && t < 2000) begin
            @(posedge clk); t++;
        end
        if (t >= 2000) chk("drain_timeout", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_byte_cnt"}, byte_cnt, BW'(m_cnt));
        chk({tag, "_drop_cnt"}, drop_cnt, m_drop);
        chk({tag, "_partial_err"}, partial_err, m_perr);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; clr_status = 1'b1;
        @(posedge clk); #1; clr_status = 1'b0;
        m_perr = 0; m_drop = 0;
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, nb, ex, gpb;
        logic [1:0] lm;
        enable = 1'b1; cpol = 1'b0; cpha = 1'b0; lane_mode = 2'd0; clr_status = 1'b0;
        spi_clk = 1'b0; spi_cs = 1'b1; spi_dq = '0; out_ready = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sof", out_sof, 0);
        check_status("rst");
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;

        // Mode 0 x1, two bytes
        fbytes[0] = 8'hA5; fbytes[1] = 8'h3C;
        spi_frame(0, 0, 2'd0, 2, 0, 0);
        drain();
        chk("t1_byte_cnt", byte_cnt, 2);
        check_status("t1");

        // Raw completing edge to out_valid latency
        fbytes[0] = 8'h5A;
        lat = 0;
        fork
            spi_frame(0, 0, 2'd0, 1, 0, 0);
            begin
                @(byte_edge);
                while (lat < 20) begin
                    @(posedge clk); lat++; #1;
                    if (out_valid) break;
                end
            end
        join
        chk("latency", lat, SYNC + 3);
        drain();

        // Mode 3 x4, then lane_mode 3 treated as x4 in a new frame
        fbytes[0] = 8'h9F;
        spi_frame(1, 1, 2'd2, 1, 0, 0);
        fbytes[0] = 8'h01;
        spi_frame(1, 1, 2'd3, 1, 0, 0);
        drain();
        check_status("t2");

        // x2, frame ends after 3 edges
        spi_frame(0, 1, 2'd1, 0, 3, 0);
        drain();
        check_status("t3");
        pulse_clr();
        check_status("t3_clr");

        // Overflow with ready held low
        out_ready = 1'b0; accept_cap = DEPTH;
        for (int i = 0; i < 6; i++) fbytes[i] = 8'($urandom);
        spi_frame(0, 0, 2'd0, 6, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        check_status("t4");
        chk("t4_valid", out_valid, 1);
        accept_cap = 1000; out_ready = 1'b1;
        drain();
        pulse_clr();
        check_status("t4_clr");

        // Config changed mid-frame; current frame keeps old settings
        fbytes[0] = 8'hC3; fbytes[1] = 8'h7E;
        spi_frame(1, 0, 2'd0, 2, 0, 1);
        fbytes[0] = 8'h18; fbytes[1] = 8'hE7;
        spi_frame(0, 0, 2'd2, 2, 0, 0);
        drain();
        check_status("t5");

        // Reset mid-stream (bytes held) and mid-frame
        out_ready = 1'b0; accept_cap = DEPTH;
        fbytes[0] = 8'h11; fbytes[1] = 8'h22;
        spi_frame(0, 0, 2'd2, 2, 0, 0);
        model_on = 0;
        fbytes[0] = 8'h33; fbytes[1] = 8'h44; fbytes[2] = 8'h55;
        fork
            spi_frame(0, 0, 2'd0, 3, 0, 0);
            begin
                repeat (60) @(posedge clk);
                #1 rst = 1'b0;
                #1;
                chk("t6_valid", out_valid, 0);
                chk("t6_data", out_data, 0);
                chk("t6_sof", out_sof, 0);
                sb_q.delete(); m_cnt = 0; m_drop = 0; m_perr = 0;
                check_status("t6_rst");
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        model_on = 1; accept_cap = 1000; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        chk("t6_after_valid", out_valid, 0);
        check_status("t6_after");
        fbytes[0] = 8'hD2; fbytes[1] = 8'h4B;
        spi_frame(1, 1, 2'd1, 2, 0, 0);
        drain();
        check_status("t6_frame");

        // Randomised frames with random backpressure
        rand_ready = 1;
        for (int f = 0; f < 24; f++) begin
            lm  = 2'($urandom_range(3));
            gpb = (lm == 2'd0) ? 8 : (lm == 2'd1) ? 4 : 2;
            nb  = $urandom_range(1, 4);
            ex  = ($urandom_range(3) == 0) ? $urandom_range(1, gpb - 1) : 0;
            for (int i = 0; i < nb; i++) fbytes[i] = 8'($urandom);
            spi_frame(1'($urandom), 1'($urandom), lm, nb, ex, 0);
            drain();
            check_status("rnd");
            if (m_perr) pulse_clr();
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        chk("final_queue_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
